// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rom_port_arbiter
//  Purpose  : Shares one toggle-handshake DDRAM port between the ROM loader
//             (writes), the 68K CPU (reads) and the VDP DMA engine (reads).
//             One downstream transaction is outstanding at a time.
//             Grant order in IDLE is LD > readers; reads are blocked while
//             LOADING is high.
//  Config   : `define ROM_ARB_RR_EN -> CPU/DMA round-robin when both pend.
//             Undefined             -> fixed CPU > DMA.
//  Revision : 1.0  initial release
// ============================================================================
module rom_port_arbiter (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        LOADING,

    // loader write client
    input  logic [24:1] LD_ADDR,
    input  logic [15:0] LD_DATA,
    input  logic        LD_REQ,
    output logic        LD_ACK,

    // 68K read client
    input  logic [23:0] CPU_ADDR,
    input  logic        CPU_REQ,
    output logic        CPU_ACK,
    output logic [15:0] CPU_DATA,

    // VDP DMA read client
    input  logic [23:0] DMA_ADDR,
    input  logic        DMA_REQ,
    output logic        DMA_ACK,
    output logic [15:0] DMA_DATA,

    // shared DDRAM toggle port
    output logic [23:0] MEM_ADDR,
    output logic [15:0] MEM_DIN,
    output logic        MEM_WE_REQ,
    input  logic        MEM_WE_ACK,
    output logic        MEM_RD_REQ,
    input  logic        MEM_RD_ACK,
    input  logic [15:0] MEM_DOUT,

    output logic        BUSY
);

    // ------------------------------------------------------------------
    // State encoding and read-owner encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WR_WAIT = 2'd1;
    localparam logic [1:0] c_RD_WAIT = 2'd2;

    localparam logic       c_OWN_CPU = 1'b0;
    localparam logic       c_OWN_DMA = 1'b1;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        r_ld_ack;
    logic        r_cpu_ack;
    logic        r_dma_ack;
    logic [15:0] r_cpu_data;
    logic [15:0] r_dma_data;
    logic [23:0] r_mem_addr;
    logic [15:0] r_mem_din;
    logic        r_mem_we_req;
    logic        r_mem_rd_req;
    logic        r_owner;
    logic        w_busy;

    logic        w_idle;
    logic        w_ld_pend;
    logic        w_cpu_elig;
    logic        w_dma_elig;
    logic        w_grant_ld;
    logic        w_grant_cpu;
    logic        w_grant_dma;
    logic        w_wr_done;
    logic        w_rd_done;

    // ------------------------------------------------------------------
    // Pending detection: a client pends while its REQ differs from ACK.
    // A second toggle while owned simply cancels the first, so the
    // ACK issued on completion leaves REQ == ACK and no extra transaction
    // is started.
    // ------------------------------------------------------------------
    assign w_idle     = (r_state == c_IDLE);
    assign w_ld_pend  = LD_REQ  ^ r_ld_ack;
    assign w_cpu_elig = (CPU_REQ ^ r_cpu_ack) & ~LOADING;
    assign w_dma_elig = (DMA_REQ ^ r_dma_ack) & ~LOADING;

    // Completion: first cycle the downstream ACK matches our REQ
    assign w_wr_done  = (r_state == c_WR_WAIT) && (MEM_WE_ACK == r_mem_we_req);
    assign w_rd_done  = (r_state == c_RD_WAIT) && (MEM_RD_ACK == r_mem_rd_req);

`ifdef ROM_ARB_RR_EN
    // Round-robin pointer: 0 favours CPU, 1 favours DMA
    logic r_rr_dma;

    // Reader grant selection with alternating preference on contention
    always_comb begin
        w_grant_ld  = w_idle & w_ld_pend;
        w_grant_cpu = 1'b0;
        w_grant_dma = 1'b0;
        if (w_idle && !w_ld_pend) begin
            if (w_cpu_elig && w_dma_elig) begin
                w_grant_cpu = ~r_rr_dma;
                w_grant_dma =  r_rr_dma;
            end else begin
                w_grant_cpu = w_cpu_elig;
                w_grant_dma = w_dma_elig;
            end
        end
    end

    // Pointer moves to the other reader after every read grant
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rr_dma <= 1'b0;
        end else if (w_grant_cpu) begin
            r_rr_dma <= 1'b1;
        end else if (w_grant_dma) begin
            r_rr_dma <= 1'b0;
        end
    end
`else
    // Fixed reader grant selection: CPU always ahead of DMA
    always_comb begin
        w_grant_ld  = w_idle & w_ld_pend;
        w_grant_cpu = w_idle & ~w_ld_pend & w_cpu_elig;
        w_grant_dma = w_idle & ~w_ld_pend & ~w_cpu_elig & w_dma_elig;
    end
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: grant enters a wait state, downstream ACK returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_ld) begin
                    w_state_nxt = c_WR_WAIT;
                end else if (w_grant_cpu || w_grant_dma) begin
                    w_state_nxt = c_RD_WAIT;
                end
            end
            c_WR_WAIT: begin
                if (w_wr_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_RD_WAIT: begin
                if (w_rd_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output decode: busy whenever a transaction is outstanding
    always_comb begin
        w_busy = (r_state != c_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Downstream request launch; address/data held until the next grant
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mem_addr   <= 24'h000000;
            r_mem_din    <= 16'h0000;
            r_mem_we_req <= 1'b0;
            r_mem_rd_req <= 1'b0;
            r_owner      <= c_OWN_CPU;
        end else if (w_grant_ld) begin
            r_mem_addr   <= LD_ADDR;
            r_mem_din    <= LD_DATA;
            r_mem_we_req <= ~r_mem_we_req;
        end else if (w_grant_cpu) begin
            r_mem_addr   <= CPU_ADDR;
            r_mem_rd_req <= ~r_mem_rd_req;
            r_owner      <= c_OWN_CPU;
        end else if (w_grant_dma) begin
            r_mem_addr   <= DMA_ADDR;
            r_mem_rd_req <= ~r_mem_rd_req;
            r_owner      <= c_OWN_DMA;
        end
    end

    // Loader acknowledge on write completion
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ld_ack <= 1'b0;
        end else if (w_wr_done) begin
            r_ld_ack <= ~r_ld_ack;
        end
    end

    // Read return: only the owner's data and ACK change
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cpu_ack  <= 1'b0;
            r_dma_ack  <= 1'b0;
            r_cpu_data <= 16'h0000;
            r_dma_data <= 16'h0000;
        end else if (w_rd_done) begin
            if (r_owner == c_OWN_DMA) begin
                r_dma_data <= MEM_DOUT;
                r_dma_ack  <= ~r_dma_ack;
            end else begin
                r_cpu_data <= MEM_DOUT;
                r_cpu_ack  <= ~r_cpu_ack;
            end
        end
    end

    assign LD_ACK     = r_ld_ack;
    assign CPU_ACK    = r_cpu_ack;
    assign CPU_DATA   = r_cpu_data;
    assign DMA_ACK    = r_dma_ack;
    assign DMA_DATA   = r_dma_data;
    assign MEM_ADDR   = r_mem_addr;
    assign MEM_DIN    = r_mem_din;
    assign MEM_WE_REQ = r_mem_we_req;
    assign MEM_RD_REQ = r_mem_rd_req;
    assign BUSY       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_port_arbiter
//  Purpose  : Directed self-checking bench for rom_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rom_port_arbiter;

    logic        MCLK = 1'b0;
    logic        RESET_N;
    logic        LOADING;
    logic [24:1] LD_ADDR;
    logic [15:0] LD_DATA;
    logic        LD_REQ;
    logic        LD_ACK;
    logic [23:0] CPU_ADDR;
    logic        CPU_REQ;
    logic        CPU_ACK;
    logic [15:0] CPU_DATA;
    logic [23:0] DMA_ADDR;
    logic        DMA_REQ;
    logic        DMA_ACK;
    logic [15:0] DMA_DATA;
    logic [23:0] MEM_ADDR;
    logic [15:0] MEM_DIN;
    logic        MEM_WE_REQ;
    logic        MEM_WE_ACK;
    logic        MEM_RD_REQ;
    logic        MEM_RD_ACK;
    logic [15:0] MEM_DOUT;
    logic        BUSY;

    int n_checks = 0;
    int n_pass   = 0;

    rom_port_arbiter dut (
        .MCLK       (MCLK),
        .RESET_N    (RESET_N),
        .LOADING    (LOADING),
        .LD_ADDR    (LD_ADDR),
        .LD_DATA    (LD_DATA),
        .LD_REQ     (LD_REQ),
        .LD_ACK     (LD_ACK),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_REQ    (CPU_REQ),
        .CPU_ACK    (CPU_ACK),
        .CPU_DATA   (CPU_DATA),
        .DMA_ADDR   (DMA_ADDR),
        .DMA_REQ    (DMA_REQ),
        .DMA_ACK    (DMA_ACK),
        .DMA_DATA   (DMA_DATA),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DIN    (MEM_DIN),
        .MEM_WE_REQ (MEM_WE_REQ),
        .MEM_WE_ACK (MEM_WE_ACK),
        .MEM_RD_REQ (MEM_RD_REQ),
        .MEM_RD_ACK (MEM_RD_ACK),
        .MEM_DOUT   (MEM_DOUT),
        .BUSY       (BUSY)
    );

    always #5 MCLK = ~MCLK;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    // Clients and memory model back to idle, then pulse reset
    task automatic do_reset();
        LOADING    = 1'b0;
        LD_ADDR    = '0;
        LD_DATA    = '0;
        LD_REQ     = 1'b0;
        CPU_ADDR   = '0;
        CPU_REQ    = 1'b0;
        DMA_ADDR   = '0;
        DMA_REQ    = 1'b0;
        MEM_WE_ACK = 1'b0;
        MEM_RD_ACK = 1'b0;
        MEM_DOUT   = '0;
        RESET_N    = 1'b0;
        tick();
        tick();
        RESET_N    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({LD_ACK, CPU_ACK, DMA_ACK} !== 3'b000) $display("FAIL reset_acks: got %b expected 000", {LD_ACK, CPU_ACK, DMA_ACK}); else n_pass++;
        n_checks++; if ({MEM_WE_REQ, MEM_RD_REQ, BUSY} !== 3'b000) $display("FAIL reset_memreq_busy: got %b expected 000", {MEM_WE_REQ, MEM_RD_REQ, BUSY}); else n_pass++;
        n_checks++; if ({CPU_DATA, DMA_DATA} !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", {CPU_DATA, DMA_DATA}); else n_pass++;
        n_checks++; if ({MEM_ADDR, MEM_DIN} !== 40'h0) $display("FAIL reset_addr_din: got %h expected 0000000000", {MEM_ADDR, MEM_DIN}); else n_pass++;
    endtask

    task automatic test_cpu_read();
        do_reset();
        CPU_ADDR = 24'h000100;
        MEM_DOUT = 16'h4E71;
        CPU_REQ  = 1'b1;
        tick();
        n_checks++; if (MEM_RD_REQ !== 1'b1) $display("FAIL cpu_rd_req_launch: got %b expected 1", MEM_RD_REQ); else n_pass++;
        n_checks++; if (MEM_ADDR !== 24'h000100) $display("FAIL cpu_mem_addr: got %h expected 000100", MEM_ADDR); else n_pass++;
        n_checks++; if (BUSY !== 1'b1) $display("FAIL cpu_busy: got %b expected 1", BUSY); else n_pass++;
        CPU_ADDR = 24'hFFFFFF;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (CPU_ACK !== 1'b0) $display("FAIL cpu_ack_early: got %b expected 0", CPU_ACK); else n_pass++;
        n_checks++; if (MEM_ADDR !== 24'h000100) $display("FAIL cpu_addr_stable: got %h expected 000100", MEM_ADDR); else n_pass++;
        MEM_RD_ACK = 1'b1;
        tick();
        n_checks++; if (CPU_ACK !== 1'b1) $display("FAIL cpu_ack: got %b expected 1", CPU_ACK); else n_pass++;
        n_checks++; if (CPU_DATA !== 16'h4E71) $display("FAIL cpu_data: got %h expected 4e71", CPU_DATA); else n_pass++;
        n_checks++; if ({BUSY, DMA_DATA} !== 17'h0) $display("FAIL cpu_done_busy_dma: got %h expected 00000", {BUSY, DMA_DATA}); else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        LD_ADDR  = 24'h000200;
        LD_DATA  = 16'hA5A5;
        CPU_ADDR = 24'h000300;
        DMA_ADDR = 24'h000400;
        LD_REQ = 1'b1; CPU_REQ = 1'b1; DMA_REQ = 1'b1;
        tick();
        n_checks++; if ({MEM_WE_REQ, MEM_RD_REQ} !== 2'b10) $display("FAIL prio_ld_first: got %b expected 10", {MEM_WE_REQ, MEM_RD_REQ}); else n_pass++;
        n_checks++; if ({MEM_ADDR, MEM_DIN} !== {24'h000200, 16'hA5A5}) $display("FAIL prio_ld_addr_din: got %h expected 000200a5a5", {MEM_ADDR, MEM_DIN}); else n_pass++;
        tick(); tick();
        n_checks++; if (MEM_RD_REQ !== 1'b0) $display("FAIL prio_no_read_in_wr: got %b expected 0", MEM_RD_REQ); else n_pass++;
        MEM_WE_ACK = 1'b1;
        tick();
        n_checks++; if ({LD_ACK, MEM_RD_REQ} !== 2'b10) $display("FAIL prio_ld_ack: got %b expected 10", {LD_ACK, MEM_RD_REQ}); else n_pass++;
        tick();
        n_checks++; if ({MEM_RD_REQ, MEM_ADDR} !== {1'b1, 24'h000300}) $display("FAIL prio_cpu_second: got %h expected 1000300", {MEM_RD_REQ, MEM_ADDR}); else n_pass++;
        MEM_DOUT = 16'h1234; MEM_RD_ACK = 1'b1;
        tick();
        n_checks++; if ({CPU_ACK, DMA_ACK, CPU_DATA} !== {2'b10, 16'h1234}) $display("FAIL prio_cpu_done: got %h expected 21234", {CPU_ACK, DMA_ACK, CPU_DATA}); else n_pass++;
        tick();
        n_checks++; if ({MEM_RD_REQ, MEM_ADDR} !== {1'b0, 24'h000400}) $display("FAIL prio_dma_third: got %h expected 0000400", {MEM_RD_REQ, MEM_ADDR}); else n_pass++;
        MEM_DOUT = 16'h5678; MEM_RD_ACK = 1'b0;
        tick();
        n_checks++; if ({DMA_ACK, DMA_DATA} !== {1'b1, 16'h5678}) $display("FAIL prio_dma_done: got %h expected 15678", {DMA_ACK, DMA_DATA}); else n_pass++;
        n_checks++; if (CPU_DATA !== 16'h1234) $display("FAIL prio_cpu_data_hold: got %h expected 1234", CPU_DATA); else n_pass++;
    endtask

    task automatic test_loading();
        do_reset();
        LOADING  = 1'b1;
        CPU_ADDR = 24'h000700;
        CPU_REQ  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({MEM_RD_REQ, BUSY} !== 2'b00) $display("FAIL load_blocks_read: got %b expected 00", {MEM_RD_REQ, BUSY}); else n_pass++;
        end
        LOADING = 1'b0;
        tick();
        n_checks++; if ({MEM_RD_REQ, MEM_ADDR} !== {1'b1, 24'h000700}) $display("FAIL load_release_grant: got %h expected 1000700", {MEM_RD_REQ, MEM_ADDR}); else n_pass++;
        MEM_DOUT = 16'hBEEF; MEM_RD_ACK = 1'b1;
        LOADING  = 1'b1;
        tick();
        n_checks++; if ({CPU_ACK, CPU_DATA} !== {1'b1, 16'hBEEF}) $display("FAIL load_read_completes: got %h expected 1beef", {CPU_ACK, CPU_DATA}); else n_pass++;
        LOADING = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [23:0] grants [4];
        logic [23:0] expect_g [4];
        logic        prev;
        int          n;
`ifdef ROM_ARB_RR_EN
        expect_g[0] = 24'h000010; expect_g[1] = 24'h000020;
        expect_g[2] = 24'h000010; expect_g[3] = 24'h000020;
`else
        expect_g[0] = 24'h000010; expect_g[1] = 24'h000010;
        expect_g[2] = 24'h000010; expect_g[3] = 24'h000010;
`endif
        do_reset();
        CPU_ADDR = 24'h000010;
        DMA_ADDR = 24'h000020;
        CPU_REQ  = 1'b1;
        DMA_REQ  = 1'b1;
        prev = MEM_RD_REQ;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            tick();
            if (MEM_RD_REQ !== prev) begin
                grants[n] = MEM_ADDR;
                n++;
                prev = MEM_RD_REQ;
            end
            if (MEM_RD_ACK !== MEM_RD_REQ) MEM_RD_ACK = MEM_RD_REQ;
            if (CPU_REQ == CPU_ACK) CPU_REQ = ~CPU_REQ;
            if (DMA_REQ == DMA_ACK) DMA_REQ = ~DMA_REQ;
        end
        n_checks++; if (n !== 4) $display("FAIL rr_grant_count: got %0d expected 4", n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                n_checks++; if (grants[i] !== expect_g[i]) $display("FAIL rr_grant_%0d: got %h expected %h", i, grants[i], expect_g[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        CPU_ADDR = 24'h000500;
        MEM_DOUT = 16'h9999;
        CPU_REQ  = 1'b1;
        tick();
        n_checks++; if ({MEM_RD_REQ, BUSY} !== 2'b11) $display("FAIL rstmid_launch: got %b expected 11", {MEM_RD_REQ, BUSY}); else n_pass++;
        tick();
        RESET_N = 1'b0;
        CPU_REQ = 1'b0;
        #1;
        n_checks++; if ({MEM_RD_REQ, BUSY, CPU_ACK} !== 3'b000) $display("FAIL rstmid_async: got %b expected 000", {MEM_RD_REQ, BUSY, CPU_ACK}); else n_pass++;
        n_checks++; if (MEM_ADDR !== 24'h000000) $display("FAIL rstmid_addr: got %h expected 000000", MEM_ADDR); else n_pass++;
        tick(); tick();
        RESET_N = 1'b1;
        tick();
        MEM_RD_ACK = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if ({CPU_ACK, CPU_DATA, BUSY} !== 18'h0) $display("FAIL rstmid_no_late_ack: got %h expected 00000", {CPU_ACK, CPU_DATA, BUSY}); else n_pass++;
        end
        MEM_RD_ACK = 1'b0;
    endtask

    task automatic test_double_toggle();
        do_reset();
        DMA_ADDR = 24'h000600;
        DMA_REQ  = 1'b1;
        tick();
        n_checks++; if ({MEM_RD_REQ, MEM_ADDR} !== {1'b1, 24'h000600}) $display("FAIL dbl_launch: got %h expected 1000600", {MEM_RD_REQ, MEM_ADDR}); else n_pass++;
        DMA_REQ = 1'b0;
        tick();
        DMA_REQ = 1'b1;
        tick();
        MEM_DOUT = 16'hCAFE; MEM_RD_ACK = 1'b1;
        tick();
        n_checks++; if ({DMA_ACK, DMA_DATA} !== {1'b1, 16'hCAFE}) $display("FAIL dbl_done: got %h expected 1cafe", {DMA_ACK, DMA_DATA}); else n_pass++;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if ({MEM_RD_REQ, BUSY} !== 2'b10) $display("FAIL dbl_no_second_txn: got %b expected 10", {MEM_RD_REQ, BUSY}); else n_pass++;
        n_checks++; if (DMA_ACK !== DMA_REQ) $display("FAIL dbl_ack_eq_req: got %b expected %b", DMA_ACK, DMA_REQ); else n_pass++;
    endtask

    initial begin
        RESET_N = 1'b0;
        test_reset();
        test_cpu_read();
        test_priority();
        test_loading();
        test_round_robin();
        test_reset_mid_read();
        test_double_toggle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
